// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : note_sequencer
//  Purpose  : Pattern-driven step sequencer feeding 16 just-intonation voice
//             frequencies, a filter cutoff and a gate to the synthesizer.
//             Optional build macro SEQ_GLIDE_EN adds per-sample portamento.
//  Revision : 1.0  initial release
// ============================================================================
module note_sequencer #(
    parameter int STEPS     = 16,
    parameter int BASE_FREQ = 110,
    parameter int FRAC      = 20
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sample_tick,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop,
    input  logic [$clog2(STEPS):0]     pattern_len,
    input  logic [31:0]                step_samples,
    input  logic                       wr_en,
    input  logic [$clog2(STEPS)-1:0]   wr_addr,
    input  logic [14:0]                wr_data,
    output logic [15:0][31:0]          frequency,
    output logic [2:0]                 cutoff,
    output logic                       gate,
    output logic                       busy,
    output logic [$clog2(STEPS)-1:0]   step_index,
    output logic                       done
);

    localparam int          c_aw        = $clog2(STEPS);
    localparam int          c_frac_up   = (FRAC > 20) ? FRAC - 20 : 0;
    localparam int          c_frac_dn   = (FRAC < 20) ? 20 - FRAC : 0;
    localparam logic [31:0] c_base_freq = 32'(BASE_FREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CALC  = 2'd2,
        S_PLAY  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [14:0]        r_pattern [STEPS];
    logic [14:0]        r_entry;
    logic [c_aw-1:0]    r_step_index;
    logic [31:0]        r_base;
    logic [2:0]         r_cutoff;
    logic               r_gate;
    logic               r_done;
    logic [39:0]        r_dur;
    logic [39:0]        r_cnt;

    logic [3:0]         w_tone;
    logic [7:0]         w_len;
    logic [31:0]        w_rom;
    logic [31:0]        w_ratio;
    logic [31:0]        w_base;
    logic [31:0]        w_ss;
    logic [39:0]        w_dur;
    logic               w_is_note;
    logic               w_more;
    logic               w_start_ok;
    logic               w_adv;
    logic               w_end;
    logic               w_done_set;

    assign w_tone    = r_entry[14:11];
    assign w_len     = r_entry[10:3];
    assign w_is_note = (w_tone <= 4'd12);
    assign w_ss      = (step_samples == 32'd0) ? 32'd1 : step_samples;
    assign w_dur     = {32'd0, w_len} * {8'd0, w_ss};
    assign w_more    = (({1'b0, r_step_index}) + {{c_aw{1'b0}}, 1'b1}) < pattern_len;

    // Q20 just-intonation ratios over one octave
    always_comb begin
        w_rom = 32'd0;
        case (w_tone)
            4'd0:    w_rom = 32'd1048576;
            4'd1:    w_rom = 32'd1118481;
            4'd2:    w_rom = 32'd1179648;
            4'd3:    w_rom = 32'd1258291;
            4'd4:    w_rom = 32'd1310720;
            4'd5:    w_rom = 32'd1398101;
            4'd6:    w_rom = 32'd1474560;
            4'd7:    w_rom = 32'd1572864;
            4'd8:    w_rom = 32'd1677721;
            4'd9:    w_rom = 32'd1747626;
            4'd10:   w_rom = 32'd1864135;
            4'd11:   w_rom = 32'd1966080;
            4'd12:   w_rom = 32'd2097152;
            default: w_rom = 32'd0;
        endcase
    end

    assign w_ratio = (w_rom << c_frac_up) >> c_frac_dn;
    assign w_base  = c_base_freq * w_ratio;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_adv        = 1'b0;
        w_end        = 1'b0;
        w_done_set   = 1'b0;
        if (stop) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (pattern_len != '0) begin
                            w_state_next = S_FETCH;
                            w_start_ok   = 1'b1;
                        end else begin
                            w_done_set = 1'b1;
                        end
                    end
                end
                S_FETCH: w_state_next = S_CALC;
                S_CALC: begin
                    if (w_len == 8'd0) w_adv = 1'b1;
                    else               w_state_next = S_PLAY;
                end
                S_PLAY: begin
                    if (sample_tick && ((r_cnt + 40'd1) >= r_dur)) w_adv = 1'b1;
                end
                default: w_state_next = S_IDLE;
            endcase
            if (w_adv) begin
                if (w_more || loop) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_IDLE;
                    w_end        = 1'b1;
                    w_done_set   = 1'b1;
                end
            end
        end
    end

    // Pattern RAM and its read register carry no reset
    always_ff @(posedge clk) begin
        if (wr_en) r_pattern[wr_addr] <= wr_data;
        if (r_state == S_FETCH) r_entry <= r_pattern[r_step_index];
    end

`ifdef SEQ_GLIDE_EN
    logic [31:0]        r_target;
    logic               r_first;
    logic signed [31:0] w_diff;
    logic               w_snap;

    assign w_diff = $signed(r_target) - $signed(r_base);
    assign w_snap = (w_diff > -32'sd16) && (w_diff < 32'sd16);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_step_index <= '0;
            r_base       <= 32'd0;
            r_cutoff     <= 3'd0;
            r_gate       <= 1'b0;
            r_done       <= 1'b0;
            r_dur        <= 40'd0;
            r_cnt        <= 40'd0;
`ifdef SEQ_GLIDE_EN
            r_target     <= 32'd0;
            r_first      <= 1'b0;
`endif
        end else begin
            r_done <= w_done_set;
            if (stop) begin
                r_gate <= 1'b0;
            end else begin
                if (w_start_ok) begin
                    r_step_index <= '0;
`ifdef SEQ_GLIDE_EN
                    r_first      <= 1'b1;
`endif
                end
                if (r_state == S_CALC) begin
                    r_cutoff <= r_entry[2:0];
                    r_dur    <= w_dur;
                    r_cnt    <= 40'd0;
                    r_gate   <= w_is_note;
`ifdef SEQ_GLIDE_EN
                    if (w_is_note) begin
                        r_target <= w_base;
                        if (r_first) begin
                            r_base  <= w_base;
                            r_first <= 1'b0;
                        end
                    end
                end else if (sample_tick && r_gate && (r_state != S_IDLE)) begin
                    r_base <= w_snap ? r_target : (r_base + $unsigned(w_diff >>> 4));
`else
                    if (w_is_note) r_base <= w_base;
`endif
                end
                if ((r_state == S_PLAY) && sample_tick) r_cnt <= r_cnt + 40'd1;
                if (w_adv) begin
                    if (w_more)    r_step_index <= r_step_index + c_aw'(1);
                    else if (loop) r_step_index <= '0;
                end
                if (w_end) r_gate <= 1'b0;
            end
        end
    end

    // Voice i sounds at base times 1, 2 or 4 depending on i mod 3
    for (genvar gi = 0; gi < 16; gi++) begin : g_voice
        assign frequency[gi] = r_base << (gi % 3);
    end

    assign cutoff     = r_cutoff;
    assign gate       = r_gate;
    assign busy       = (r_state != S_IDLE);
    assign step_index = r_step_index;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_note_sequencer
//  Purpose  : Directed self-checking bench for note_sequencer (default build).
//  Revision : 1.0  initial release
// ============================================================================
module tb_note_sequencer;

    logic             clk;
    logic             reset_n;
    logic             sample_tick;
    logic             start;
    logic             stop;
    logic             loop;
    logic [4:0]       pattern_len;
    logic [31:0]      step_samples;
    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [14:0]      wr_data;
    logic [15:0][31:0] frequency;
    logic [2:0]       cutoff;
    logic             gate;
    logic             busy;
    logic [3:0]       step_index;
    logic             done;

    int n_checks = 0;
    int n_fails  = 0;

    note_sequencer #(.STEPS(16), .BASE_FREQ(110), .FRAC(20)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_tick  (sample_tick),
        .start        (start),
        .stop         (stop),
        .loop         (loop),
        .pattern_len  (pattern_len),
        .step_samples (step_samples),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frequency    (frequency),
        .cutoff       (cutoff),
        .gate         (gate),
        .busy         (busy),
        .step_index   (step_index),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic write_entry(input logic [3:0] addr, input logic [3:0] tone,
                               input logic [7:0] len, input logic [2:0] cut);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = {tone, len, cut};
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    endtask

    initial begin
        reset_n = 1'b0; sample_tick = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        pattern_len = 5'd0; step_samples = 32'd0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 15'd0;
        cycles(3);
        check_value("rst_freq0", frequency[0], 32'd0);
        check_value("rst_gate", {31'd0, gate}, 32'd0);
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        check_value("rst_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        cycles(1);

        // single note, tone 0
        write_entry(4'd0, 4'd0, 8'd1, 3'd1);
        pattern_len = 5'd1; step_samples = 32'd4;
        pulse_start();
        cycles(1);
        check_value("t1_gate_latency", {31'd0, gate}, 32'd0);
        cycles(1);
        check_value("t1_gate_on", {31'd0, gate}, 32'd1);
        check_value("t1_freq0", frequency[0], 32'd115343360);
        check_value("t1_freq1", frequency[1], 32'd230686720);
        check_value("t1_freq2", frequency[2], 32'd461373440);
        check_value("t1_freq3", frequency[3], 32'd115343360);
        check_value("t1_cutoff", {29'd0, cutoff}, 32'd1);
        check_value("t1_busy", {31'd0, busy}, 32'd1);
        send_ticks(3);
        check_value("t1_gate_held", {31'd0, gate}, 32'd1);
        check_value("t1_no_early_done", {31'd0, done}, 32'd0);
        send_ticks(1);
        check_value("t1_done", {31'd0, done}, 32'd1);
        check_value("t1_gate_off", {31'd0, gate}, 32'd0);
        check_value("t1_busy_off", {31'd0, busy}, 32'd0);
        cycles(1);
        check_value("t1_done_pulse", {31'd0, done}, 32'd0);
        check_value("t1_freq_hold", frequency[0], 32'd115343360);

        // two-step pattern: tone 7 len 2, tone 12 len 1
        write_entry(4'd0, 4'd7, 8'd2, 3'd2);
        write_entry(4'd1, 4'd12, 8'd1, 3'd4);
        pattern_len = 5'd2; step_samples = 32'd3;
        pulse_start();
        cycles(2);
        check_value("t2_freq_a", frequency[0], 32'd173015040);
        check_value("t2_step0", {28'd0, step_index}, 32'd0);
        send_ticks(5);
        check_value("t2_freq_a_hold", frequency[0], 32'd173015040);
        check_value("t2_step0_hold", {28'd0, step_index}, 32'd0);
        send_ticks(1);
        check_value("t2_step1", {28'd0, step_index}, 32'd1);
        check_value("t2_gate_across", {31'd0, gate}, 32'd1);
        cycles(2);
        check_value("t2_freq_b", frequency[0], 32'd230686720);
        check_value("t2_cutoff_b", {29'd0, cutoff}, 32'd4);
        send_ticks(2);
        check_value("t2_not_done", {31'd0, done}, 32'd0);
        send_ticks(1);
        check_value("t2_done", {31'd0, done}, 32'd1);

        // rest after a note
        write_entry(4'd0, 4'd0, 8'd1, 3'd0);
        write_entry(4'd1, 4'd14, 8'd2, 3'd5);
        pattern_len = 5'd2; step_samples = 32'd2;
        pulse_start();
        cycles(2);
        check_value("t3_note_gate", {31'd0, gate}, 32'd1);
        send_ticks(2);
        cycles(2);
        check_value("t3_rest_gate", {31'd0, gate}, 32'd0);
        check_value("t3_rest_freq", frequency[0], 32'd115343360);
        check_value("t3_rest_cutoff", {29'd0, cutoff}, 32'd5);
        send_ticks(3);
        check_value("t3_rest_busy", {31'd0, busy}, 32'd1);
        send_ticks(1);
        check_value("t3_done", {31'd0, done}, 32'd1);

        // looping, then stop mid-step
        write_entry(4'd0, 4'd0, 8'd1, 3'd0);
        write_entry(4'd1, 4'd4, 8'd1, 3'd0);
        pattern_len = 5'd2; step_samples = 32'd1; loop = 1'b1;
        pulse_start();
        cycles(2);
        send_ticks(1);
        check_value("t4_step1", {28'd0, step_index}, 32'd1);
        cycles(2);
        check_value("t4_freq_tone4", frequency[0], 32'd144179200);
        send_ticks(1);
        check_value("t4_wrap", {28'd0, step_index}, 32'd0);
        check_value("t4_no_done", {31'd0, done}, 32'd0);
        check_value("t4_busy", {31'd0, busy}, 32'd1);
        cycles(2);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_value("t4_stop_gate", {31'd0, gate}, 32'd0);
        check_value("t4_stop_busy", {31'd0, busy}, 32'd0);
        check_value("t4_stop_done", {31'd0, done}, 32'd0);
        loop = 1'b0;

        // start+stop together, then start with empty pattern
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check_value("t5_ss_busy", {31'd0, busy}, 32'd0);
        check_value("t5_ss_done", {31'd0, done}, 32'd0);
        pattern_len = 5'd0;
        pulse_start();
        check_value("t5_empty_done", {31'd0, done}, 32'd1);
        check_value("t5_empty_busy", {31'd0, busy}, 32'd0);
        cycles(1);
        check_value("t5_empty_pulse", {31'd0, done}, 32'd0);

        // zero-length skip and step_samples of 0
        write_entry(4'd0, 4'd0, 8'd0, 3'd2);
        write_entry(4'd1, 4'd5, 8'd1, 3'd3);
        pattern_len = 5'd2; step_samples = 32'd0;
        pulse_start();
        cycles(2);
        check_value("t6_skip_step", {28'd0, step_index}, 32'd1);
        cycles(2);
        check_value("t6_freq", frequency[0], 32'd153791110);
        check_value("t6_cutoff", {29'd0, cutoff}, 32'd3);
        send_ticks(1);
        check_value("t6_done", {31'd0, done}, 32'd1);

        // asynchronous reset mid-play
        write_entry(4'd0, 4'd3, 8'd4, 3'd6);
        pattern_len = 5'd1; step_samples = 32'd5;
        pulse_start();
        cycles(2);
        check_value("t7_playing", {31'd0, gate}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_value("t7_rst_freq", frequency[0], 32'd0);
        check_value("t7_rst_gate", {31'd0, gate}, 32'd0);
        check_value("t7_rst_busy", {31'd0, busy}, 32'd0);
        check_value("t7_rst_cutoff", {29'd0, cutoff}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
